// File: rtl/jpeg_enc_arbiter.sv
// jpeg_enc_arbiter: shares one JPEG encoder write port between NUM_REQ
// requesters at image granularity. A winner keeps the encoder across all of
// its 64-word blocks until the encoder signals end-of-stream for the image.
// Optional stall watchdog: define JPEG_ARB_TIMEOUT_EN to enable it.
module jpeg_enc_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ID_W           = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*32-1:0] wdata_i,
  input  logic [NUM_REQ-1:0]    last_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    done_o,
  output logic                  enc_req_o,
  output logic [31:0]           enc_wdata_o,
  output logic                  enc_last_o,
  input  logic                  enc_gnt_i,
  input  logic                  enc_end_i,
  output logic                  busy_o,
  output logic [ID_W-1:0]       owner_o,
  output logic                  abort_o
);

  // Reject configurations the index/owner logic cannot represent.
  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("jpeg_enc_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [5:0]      beat_cnt_q, beat_cnt_d;
  logic            blk_last_q, blk_last_d;

`ifdef JPEG_ARB_TIMEOUT_EN
  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] stall_q, stall_d;
`endif

  // Signals of the current owner, selected by owner index.
  logic               own_req;
  logic               own_last;
  logic [31:0]        own_wdata;
  logic [NUM_REQ-1:0] owner_oh;
  logic               beat_acc;
  logic [ID_W-1:0]    rr_next;

  // Round-robin pick.
  logic               pick_valid;
  logic [ID_W-1:0]    pick_idx;

  // Mux the owner's request, data and last flag; build owner one-hot.
  always_comb begin
    own_req   = 1'b0;
    own_last  = 1'b0;
    own_wdata = '0;
    owner_oh  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (int'(owner_q) == k) begin
        own_req     = req_i[k];
        own_last    = last_i[k];
        own_wdata   = wdata_i[32*k +: 32];
        owner_oh[k] = 1'b1;
      end
    end
  end

  assign beat_acc = own_req & enc_gnt_i;

  // Pointer just past the owner, wrapping at NUM_REQ.
  assign rr_next = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;

  // First requester at or after rr_ptr (wrapping): smallest rotated offset wins.
  always_comb begin
    int best_off;
    int off;
    best_off   = NUM_REQ;
    off        = 0;
    pick_idx   = '0;
    pick_valid = |req_i;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_i[k]) begin
        off = (k - int'(rr_ptr_q) + NUM_REQ) % NUM_REQ;
        if (off < best_off) begin
          best_off = off;
          pick_idx = ID_W'(k);
        end
      end
    end
  end

  // Next-state and output logic of the ownership FSM.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    blk_last_d  = blk_last_q;
    enc_req_o   = 1'b0;
    enc_wdata_o = '0;
    enc_last_o  = 1'b0;
    gnt_o       = '0;
    done_o      = '0;
    abort_o     = 1'b0;
    busy_o      = (state_q != ST_IDLE);
`ifdef JPEG_ARB_TIMEOUT_EN
    stall_d     = stall_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Arbitrate; the winner's first beat can be accepted next cycle.
        beat_cnt_d = '0;
`ifdef JPEG_ARB_TIMEOUT_EN
        stall_d = '0;
`endif
        if (pick_valid) begin
          owner_d = pick_idx;
          state_d = ST_OWN;
        end
      end

      ST_OWN: begin
        enc_req_o   = own_req;
        enc_wdata_o = own_wdata;
        enc_last_o  = own_last;
        gnt_o       = owner_oh & {NUM_REQ{enc_gnt_i}};
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + 6'd1;
          // The last-of-image flag is latched from the first beat of a block.
          if (beat_cnt_q == 6'd0) begin
            blk_last_d = own_last;
          end
          if (beat_cnt_q == 6'd63 && blk_last_q) begin
            state_d = ST_DRAIN;
          end
`ifdef JPEG_ARB_TIMEOUT_EN
          stall_d = '0;
        end else if (stall_q == STALL_LIMIT) begin
          // Owner or encoder stalled too long: drop ownership without done.
          abort_o    = 1'b1;
          rr_ptr_d   = rr_next;
          beat_cnt_d = '0;
          stall_d    = '0;
          state_d    = ST_IDLE;
        end else begin
          stall_d = stall_q + 16'd1;
`endif
        end
      end

      ST_DRAIN: begin
        // Wait for the encoder to flush the bitstream of this image.
        if (enc_end_i) begin
          done_o   = owner_oh;
          rr_ptr_d = rr_next;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Owner, round-robin pointer and block bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      blk_last_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      blk_last_q <= blk_last_d;
    end
  end

`ifdef JPEG_ARB_TIMEOUT_EN
  // Stall watchdog counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`endif

  assign owner_o = owner_q;

endmodule

// File: tb/tb_jpeg_enc_arbiter.sv
// Directed bench for jpeg_enc_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=16).
module tb_jpeg_enc_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 3;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_i;
  logic [NUM_REQ*32-1:0] wdata_i;
  logic [NUM_REQ-1:0]    last_i;
  logic [NUM_REQ-1:0]    gnt_o;
  logic [NUM_REQ-1:0]    done_o;
  logic                  enc_req_o;
  logic [31:0]           enc_wdata_o;
  logic                  enc_last_o;
  logic                  enc_gnt_i;
  logic                  enc_end_i;
  logic                  busy_o;
  logic [ID_W-1:0]       owner_o;
  logic                  abort_o;

  int errors = 0;
  int checks = 0;

  jpeg_enc_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W(ID_W),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_i(req_i),
    .wdata_i(wdata_i),
    .last_i(last_i),
    .gnt_o(gnt_o),
    .done_o(done_o),
    .enc_req_o(enc_req_o),
    .enc_wdata_o(enc_wdata_o),
    .enc_last_o(enc_last_o),
    .enc_gnt_i(enc_gnt_i),
    .enc_end_i(enc_end_i),
    .busy_o(busy_o),
    .owner_o(owner_o),
    .abort_o(abort_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pix(input int k, input int b);
    return (k == 0 ? 32'hA000_0000 : 32'hB000_0000) + 32'(b);
  endfunction

  task automatic set_wdata(input int b);
    wdata_i = {pix(1, b), pix(0, b)};
  endtask

  // Stream nbeats accepted beats from owner k. last_mode: 0 never,
  // 1 always, 2 from beat 64 of the image on, 3 only at in-block beat 5.
  task automatic stream(input int k, input int nbeats, input int last_mode,
                        input logic [NUM_REQ-1:0] other_req, input string tag);
    logic lb;
    for (int b = 0; b < nbeats; b++) begin
      case (last_mode)
        1:       lb = 1'b1;
        2:       lb = (b >= 64);
        3:       lb = ((b % 64) == 5);
        default: lb = 1'b0;
      endcase
      req_i     = other_req | NUM_REQ'(1 << k);
      last_i    = '0;
      last_i[k] = lb;
      enc_gnt_i = 1'b1;
      set_wdata(b);
      #1;
      chk({tag, "_gnt"},   gnt_o, 64'(1 << k));
      chk({tag, "_ereq"},  enc_req_o, 1);
      chk({tag, "_wdata"}, enc_wdata_o, pix(k, b));
      chk({tag, "_elast"}, enc_last_o, lb);
      chk({tag, "_owner"}, owner_o, k);
      chk({tag, "_done"},  done_o, 0);
      tick();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  busy_o, 0);
    chk({tag, "_gnt"},   gnt_o, 0);
    chk({tag, "_ereq"},  enc_req_o, 0);
    chk({tag, "_elast"}, enc_last_o, 0);
    chk({tag, "_ewd"},   enc_wdata_o, 0);
    chk({tag, "_done"},  done_o, 0);
    chk({tag, "_abort"}, abort_o, 0);
  endtask

  initial begin
    int acc;
    int drop_used;
    int stall_used;
    logic r0;
    logic g;

    rst = 1'b1; req_i = '0; wdata_i = '0; last_i = '0;
    enc_gnt_i = 1'b0; enc_end_i = 1'b0;
    tick(); tick();

    // ---- reset state ----
    check_idle_outputs("rst");
    chk("rst_owner", owner_o, 0);
    rst = 1'b0;

    // ---- single image: requester 0, one block, last on every beat ----
    req_i = 2'b01; last_i = 2'b01; enc_gnt_i = 1'b1;
    #1;
    chk("single_arb_gnt", gnt_o, 0);
    chk("single_arb_ereq", enc_req_o, 0);
    tick();
    stream(0, 64, 1, 2'b00, "single");
    req_i = '0; last_i = '0;
    for (int c = 1; c < 10; c++) begin
      #1;
      chk("single_drain_busy", busy_o, 1);
      chk("single_drain_ereq", enc_req_o, 0);
      chk("single_drain_gnt", gnt_o, 0);
      chk("single_drain_done", done_o, 0);
      tick();
    end
    enc_end_i = 1'b1;
    #1;
    chk("single_done", done_o, 2'b01);
    chk("single_done_busy", busy_o, 1);
    tick();
    enc_end_i = 1'b0;
    #1;
    chk("single_after_busy", busy_o, 0);
    chk("single_after_done", done_o, 0);
    chk("single_after_owner", owner_o, 0);
    tick();

    // ---- contention from reset: 0 wins a 2-block image, then 1 ----
    rst = 1'b1; tick(); rst = 1'b0;
    req_i = 2'b11;
    tick();
    stream(0, 128, 2, 2'b10, "cont");
    #1;
    chk("cont_drain_ereq", enc_req_o, 0);
    chk("cont_drain_gnt", gnt_o, 0);
    chk("cont_drain_busy", busy_o, 1);
    enc_end_i = 1'b1;
    #1;
    chk("cont_done", done_o, 2'b01);
    tick();
    enc_end_i = 1'b0;
    #1;
    chk("cont_idle_busy", busy_o, 0);
    chk("cont_idle_owner", owner_o, 0);
    chk("cont_idle_gnt", gnt_o, 0);
    tick();
    chk("cont_new_owner", owner_o, 1);
    chk("cont_new_busy", busy_o, 1);

    // ---- reset mid-block: requester 1 at beat 30 ----
    stream(1, 30, 0, 2'b01, "mid");
    req_i = 2'b11; enc_gnt_i = 1'b1; set_wdata(30);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid_busy", busy_o, 0);
    chk("rstmid_gnt", gnt_o, 0);
    chk("rstmid_ereq", enc_req_o, 0);
    chk("rstmid_owner", owner_o, 0);
    chk("rstmid_done", done_o, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstrel_done", done_o, 0);
    tick();
    // rr_ptr back at 0, so requester 0 wins over requester 1
    chk("rstrel_owner", owner_o, 0);

    // ---- gapped writes + last flag only on beat 0 (owner 0) ----
    acc = 0; drop_used = 0; stall_used = 0;
    for (int c = 0; c < 200 && acc < 64; c++) begin
      r0 = 1'b1; g = 1'b1;
      if (acc == 20 && drop_used < 5) begin r0 = 1'b0; drop_used++; end
      if (acc == 40 && stall_used < 3) begin g = 1'b0; stall_used++; end
      req_i = {1'b1, r0}; enc_gnt_i = g;
      last_i = {1'b0, (acc == 0)};
      set_wdata(acc);
      #1;
      chk("gap_busy", busy_o, 1);
      chk("gap_owner", owner_o, 0);
      chk("gap_ereq", enc_req_o, r0);
      chk("gap_gnt", gnt_o, {1'b0, g});
      if (gnt_o[0] && req_i[0]) acc++;
      tick();
    end
    chk("gap_beats", acc, 64);
    req_i = 2'b11; enc_gnt_i = 1'b1; last_i = '0;
    #1;
    chk("gap_drain_ereq", enc_req_o, 0);
    chk("gap_drain_busy", busy_o, 1);
    enc_end_i = 1'b1;
    #1;
    chk("gap_done", done_o, 2'b01);
    tick();
    enc_end_i = 1'b0;
    tick();
    chk("lf_owner", owner_o, 1);

    // ---- last flag on in-block beat 5 only: must not drain ----
    stream(1, 64, 3, 2'b01, "lf1");
    req_i = 2'b11; last_i = 2'b10; set_wdata(0);
    #1;
    chk("lf1_still_own", enc_req_o, 1);
    chk("lf1_still_gnt", gnt_o, 2'b10);
    // End pulse while owning is ignored.
    enc_end_i = 1'b1;
    #1;
    chk("lf1_end_ignored", done_o, 0);
    tick();
    enc_end_i = 1'b0;
    chk("lf1_end_busy", busy_o, 1);
    // Beat 0 of block 2 was just accepted with last=1; finish the block.
    for (int b = 1; b < 64; b++) begin
      req_i = 2'b11; last_i = 2'b00; set_wdata(b);
      #1;
      chk("lf2_ereq", enc_req_o, 1);
      tick();
    end
    #1;
    chk("lf2_drain_ereq", enc_req_o, 0);
    chk("lf2_drain_busy", busy_o, 1);
    req_i = '0;
    enc_end_i = 1'b1;
    #1;
    chk("lf2_done", done_o, 2'b10);
    tick();
    // End pulse in IDLE is ignored.
    #1;
    chk("idle_end_done", done_o, 0);
    chk("idle_end_busy", busy_o, 0);
    chk("idle_end_owner", owner_o, 1);
    tick();
    enc_end_i = 1'b0;

`ifdef JPEG_ARB_TIMEOUT_EN
    // ---- watchdog: owner 0 stalls after 10 beats ----
    req_i = 2'b11;
    tick();
    stream(0, 10, 0, 2'b10, "wd");
    enc_gnt_i = 1'b0;
    for (int c = 1; c < 16; c++) begin
      #1;
      chk("wd_wait_abort", abort_o, 0);
      chk("wd_wait_busy", busy_o, 1);
      tick();
    end
    #1;
    chk("wd_abort", abort_o, 1);
    chk("wd_abort_done", done_o, 0);
    tick();
    chk("wd_idle_busy", busy_o, 0);
    chk("wd_idle_abort", abort_o, 0);
    tick();
    chk("wd_next_owner", owner_o, 1);
    chk("wd_next_busy", busy_o, 1);
`else
    chk("abort_tied", abort_o, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
